// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: widths, opcodes, ALU classes and the decoded control bundle.
package pipeline_defs;

    localparam int PC_W   = 11;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_R   = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_LUI = 3'd6;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/register_file.sv
// Register file: two combinational read ports with write-through bypass, one write port,
// register 0 hardwired to zero.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int NumRegs = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic                  wr_en;

    assign wr_en = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A write landing this edge is visible to the reader in the same cycle.
    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            rdata_a = (wr_en && waddr == raddr_a) ? wdata : regs_q[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            rdata_b = (wr_en && waddr == raddr_b) ? wdata : regs_q[raddr_b];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: IF/ID register, register file, opcode decoder, load-use hazard detection
// and the ID/EX register feeding execute.
module instruction_decode
    import pipeline_defs::*;
#(
    parameter int PC_WIDTH       = PC_W,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int REG_ADDR_WIDTH = REG_AW
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [PC_WIDTH-1:0]       pc_in,
    input  logic [DATA_WIDTH-1:0]     instruccion,
    input  logic                      flush,
    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      stall,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic [DATA_WIDTH-1:0]     rs_data,
    output logic [DATA_WIDTH-1:0]     rt_data,
    output logic [DATA_WIDTH-1:0]     imm_ext,
    output logic [REG_ADDR_WIDTH-1:0] rs,
    output logic [REG_ADDR_WIDTH-1:0] rt,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      reg_write,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      mem_to_reg,
    output logic                      alu_src,
    output logic                      reg_dst,
    output logic                      branch,
    output logic [2:0]                alu_op
);

    logic [PC_WIDTH-1:0]       ifid_pc_q, ifid_pc_d;
    logic [DATA_WIDTH-1:0]     ifid_instr_q, ifid_instr_d;

    logic [5:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] f_rs, f_rt, f_rd;
    logic [15:0]               imm16;
    logic [DATA_WIDTH-1:0]     rf_rs_data, rf_rt_data;
    logic [DATA_WIDTH-1:0]     dec_imm;
    ctrl_t                     dec_ctrl;
    logic                      reads_rt;

    logic [PC_WIDTH-1:0]       idex_pc_q, idex_pc_d;
    logic [DATA_WIDTH-1:0]     idex_rs_data_q, idex_rs_data_d;
    logic [DATA_WIDTH-1:0]     idex_rt_data_q, idex_rt_data_d;
    logic [DATA_WIDTH-1:0]     idex_imm_q, idex_imm_d;
    logic [REG_ADDR_WIDTH-1:0] idex_rs_q, idex_rs_d;
    logic [REG_ADDR_WIDTH-1:0] idex_rt_q, idex_rt_d;
    logic [REG_ADDR_WIDTH-1:0] idex_rd_q, idex_rd_d;
    ctrl_t                     idex_ctrl_q, idex_ctrl_d;

    assign opcode = ifid_instr_q[31:26];
    assign f_rs   = ifid_instr_q[25:21];
    assign f_rt   = ifid_instr_q[20:16];
    assign f_rd   = ifid_instr_q[15:11];
    assign imm16  = ifid_instr_q[15:0];

    assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);

    assign stall = idex_ctrl_q.mem_read && (idex_rt_q != '0) &&
                   ((idex_rt_q == f_rs) || (reads_rt && (idex_rt_q == f_rt)));

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (flush) begin
            ifid_pc_d    = '0;
            ifid_instr_d = '0;
        end else if (!stall) begin
            ifid_pc_d    = pc_in;
            ifid_instr_d = instruccion;
        end
    end

    register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_register_file (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (f_rs),
        .raddr_b (f_rt),
        .rdata_a (rf_rs_data),
        .rdata_b (rf_rt_data),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // Unknown opcodes fall through with all controls clear, i.e. a bubble.
    always_comb begin
        dec_ctrl = '0;
        dec_imm  = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.reg_dst   = 1'b1;
                dec_ctrl.alu_op    = ALU_R;
            end
            OP_LW: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI, OP_SLTI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = (opcode == OP_ADDI) ? ALU_ADD : ALU_SLT;
            end
            OP_ANDI, OP_ORI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                dec_imm            = {{(DATA_WIDTH-16){1'b0}}, imm16};
            end
            OP_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_LUI;
                dec_imm            = {imm16, {(DATA_WIDTH-16){1'b0}}};
            end
            default: ;
        endcase
    end

    always_comb begin
        idex_pc_d      = '0;
        idex_rs_data_d = '0;
        idex_rt_data_d = '0;
        idex_imm_d     = '0;
        idex_rs_d      = '0;
        idex_rt_d      = '0;
        idex_rd_d      = '0;
        idex_ctrl_d    = '0;
        if (!stall) begin
            idex_pc_d      = ifid_pc_q;
            idex_rs_data_d = rf_rs_data;
            idex_rt_data_d = rf_rt_data;
            idex_imm_d     = dec_imm;
            idex_rs_d      = f_rs;
            idex_rt_d      = f_rt;
            idex_rd_d      = f_rd;
            idex_ctrl_d    = dec_ctrl;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid_pc_q      <= '0;
            ifid_instr_q   <= '0;
            idex_pc_q      <= '0;
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_rs_q      <= '0;
            idex_rt_q      <= '0;
            idex_rd_q      <= '0;
            idex_ctrl_q    <= '0;
        end else begin
            ifid_pc_q      <= ifid_pc_d;
            ifid_instr_q   <= ifid_instr_d;
            idex_pc_q      <= idex_pc_d;
            idex_rs_data_q <= idex_rs_data_d;
            idex_rt_data_q <= idex_rt_data_d;
            idex_imm_q     <= idex_imm_d;
            idex_rs_q      <= idex_rs_d;
            idex_rt_q      <= idex_rt_d;
            idex_rd_q      <= idex_rd_d;
            idex_ctrl_q    <= idex_ctrl_d;
        end
    end

    assign pc_out     = idex_pc_q;
    assign rs_data    = idex_rs_data_q;
    assign rt_data    = idex_rt_data_q;
    assign imm_ext    = idex_imm_q;
    assign rs         = idex_rs_q;
    assign rt         = idex_rt_q;
    assign rd         = idex_rd_q;
    assign reg_write  = idex_ctrl_q.reg_write;
    assign mem_read   = idex_ctrl_q.mem_read;
    assign mem_write  = idex_ctrl_q.mem_write;
    assign mem_to_reg = idex_ctrl_q.mem_to_reg;
    assign alu_src    = idex_ctrl_q.alu_src;
    assign reg_dst    = idex_ctrl_q.reg_dst;
    assign branch     = idex_ctrl_q.branch;
    assign alu_op     = idex_ctrl_q.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios plus a randomized run,
// all compared against a cycle-level reference model of the decode stage.
module tb_instruction_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] pc_in;
    logic [31:0] instruccion;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic [10:0] pc_out;
    logic [31:0] rs_data, rt_data, imm_ext;
    logic [4:0]  rs, rt, rd;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch;
    logic [2:0]  alu_op;

    typedef struct packed {
        logic [10:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic [2:0]  alu_op;
    } idex_t;

    idex_t dut_vec;
    assign dut_vec = {pc_out, rs_data, rt_data, imm_ext, rs, rt, rd, reg_write, mem_read,
                      mem_write, mem_to_reg, alu_src, reg_dst, branch, alu_op};

    instruction_decode dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .instruccion (instruccion),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall       (stall),
        .pc_out      (pc_out),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm_ext     (imm_ext),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .branch      (branch),
        .alu_op      (alu_op)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [10:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    idex_t       m_idex;

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic idex_t ref_decode(input logic [10:0] pc, input logic [31:0] ins);
        idex_t       e;
        logic [5:0]  op;
        logic [15:0] im;
        e  = '0;
        op = ins[31:26];
        im = ins[15:0];
        e.pc      = pc;
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.rd      = ins[15:11];
        e.rs_data = ref_read(e.rs);
        e.rt_data = ref_read(e.rt);
        e.imm     = {{16{im[15]}}, im};
        if (op == 6'h0C || op == 6'h0D) e.imm = {16'h0, im};
        if (op == 6'h0F) e.imm = {im, 16'h0};
        case (op)
            6'h00: begin e.reg_write = 1; e.reg_dst = 1; e.alu_op = 3'd2; end
            6'h23: begin
                e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1; e.alu_src = 1;
                e.alu_op = 3'd0;
            end
            6'h2B: begin e.mem_write = 1; e.alu_src = 1; e.alu_op = 3'd0; end
            6'h04: begin e.branch = 1; e.alu_op = 3'd1; end
            6'h08: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd0; end
            6'h0A: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd5; end
            6'h0C: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd3; end
            6'h0D: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd4; end
            6'h0F: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd6; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic ref_stall();
        logic [5:0] op;
        logic       uses_rt;
        op      = m_ifid_instr[31:26];
        uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h2B);
        return m_idex.mem_read && (m_idex.rt != 5'd0) &&
               ((m_idex.rt == m_ifid_instr[25:21]) ||
                (uses_rt && m_idex.rt == m_ifid_instr[20:16]));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ifid_pc    = '0;
        m_ifid_instr = '0;
        m_idex       = '0;
    endtask

    task automatic drive(input logic [10:0] p, input logic [31:0] ins, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        pc_in = p; instruccion = ins; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    // One clock edge on both DUT and model; leaves time 1 unit after the edge.
    task automatic step();
        idex_t nxt;
        logic  st;
        st  = ref_stall();
        nxt = st ? idex_t'('0) : ref_decode(m_ifid_pc, m_ifid_instr);
        if (flush) begin
            m_ifid_pc = '0; m_ifid_instr = '0;
        end else if (!st) begin
            m_ifid_pc = pc_in; m_ifid_instr = instruccion;
        end
        if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        @(posedge clock);
        #1;
        m_idex = nxt;
    endtask

    task automatic do_reset();
        drive(11'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(11'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        model_clear();
        @(posedge clock);
        #1;
        n_total++;
        if (dut_vec !== idex_t'('0) || stall !== 1'b0)
            $display("FAIL reset_init: got outs=%h stall=%b, want 0 and 0", dut_vec, stall);
        else n_pass++;
        reset = 1'b0;
        // Build up nonzero outputs, then hit reset mid-cycle
        drive(11'h155, 32'h3C01ABCD, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF);
        step();
        drive(11'h156, 32'h00E71820, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (dut_vec !== m_idex)
            $display("FAIL reset_prefill: got %h, want %h", dut_vec, m_idex);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (dut_vec !== idex_t'('0) || stall !== 1'b0)
            $display("FAIL reset_async: got outs=%h stall=%b, want 0 and 0", dut_vec, stall);
        else n_pass++;
        #1;
        reset = 1'b0;
        model_clear();
        // Registers must be cleared: add $3,$7,$7 reads zero
        drive(11'h10, 32'h00E71820, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        step();
        n_total++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0)
            $display("FAIL reset_regs: got rs=%h rt=%h, want 0 0", rs_data, rt_data);
        else n_pass++;
    endtask

    task automatic test_writeback();
        do_reset();
        drive(11'h21, 32'h00A01820, 1'b0, 1'b1, 5'd5, 32'h0000ABCD);
        step();
        drive(11'h22, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (rs_data !== 32'h0000ABCD || rt_data !== 32'd0 || reg_write !== 1'b1 ||
            reg_dst !== 1'b1 || rd !== 5'd3 || alu_op !== 3'd2 || pc_out !== 11'h21)
            $display("FAIL writeback_read: got rs=%h rt=%h rw=%b rdst=%b rd=%0d alu=%0d pc=%h, want 0000abcd 0 1 1 3 2 021",
                     rs_data, rt_data, reg_write, reg_dst, rd, alu_op, pc_out);
        else n_pass++;
        n_total++;
        if (dut_vec !== m_idex)
            $display("FAIL writeback_model: got %h, want %h", dut_vec, m_idex);
        else n_pass++;
    endtask

    task automatic test_bypass();
        do_reset();
        drive(11'h30, 32'h00A01820, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(11'h31, 32'h00001820, 1'b0, 1'b1, 5'd5, 32'h12345678);
        step();
        n_total++;
        if (rs_data !== 32'h12345678)
            $display("FAIL bypass_rs: got %h, want 12345678", rs_data);
        else n_pass++;
        drive(11'h32, 32'h00001820, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        step();
        n_total++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0)
            $display("FAIL bypass_r0: got rs=%h rt=%h, want 0 0", rs_data, rt_data);
        else n_pass++;
        drive(11'h33, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (rs_data !== 32'd0 || dut_vec !== m_idex)
            $display("FAIL r0_after_write: got rs=%h vec=%h, want 0 and %h", rs_data, dut_vec, m_idex);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(11'h40, 32'h8C220004, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(11'h41, 32'h00432020, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (stall !== 1'b1 || mem_read !== 1'b1 || rt !== 5'd2)
            $display("FAIL loaduse_stall: got stall=%b mr=%b rt=%0d, want 1 1 2", stall, mem_read, rt);
        else n_pass++;
        step();
        n_total++;
        if (stall !== 1'b0 || {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst,
                               branch, alu_op} !== 10'd0 || pc_out !== 11'd0)
            $display("FAIL loaduse_bubble: got stall=%b outs=%h, want stall 0 and zero bubble", stall, dut_vec);
        else n_pass++;
        drive(11'h42, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (pc_out !== 11'h41 || rs !== 5'd2 || rt !== 5'd3 || rd !== 5'd4 || reg_write !== 1'b1 ||
            dut_vec !== m_idex)
            $display("FAIL loaduse_issue: got pc=%h rs=%0d rt=%0d rd=%0d rw=%b, want 041 2 3 4 1",
                     pc_out, rs, rt, rd, reg_write);
        else n_pass++;
    endtask

    task automatic test_immediates();
        do_reset();
        drive(11'h50, 32'h2001FFFF, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(11'h51, 32'h3401FFFF, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (imm_ext !== 32'hFFFFFFFF || alu_src !== 1'b1 || alu_op !== 3'd0)
            $display("FAIL imm_addi: got imm=%h src=%b alu=%0d, want ffffffff 1 0", imm_ext, alu_src, alu_op);
        else n_pass++;
        drive(11'h52, 32'h3C011234, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (imm_ext !== 32'h0000FFFF || alu_op !== 3'd4)
            $display("FAIL imm_ori: got imm=%h alu=%0d, want 0000ffff 4", imm_ext, alu_op);
        else n_pass++;
        drive(11'h53, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (imm_ext !== 32'h12340000 || alu_op !== 3'd6 || reg_write !== 1'b1)
            $display("FAIL imm_lui: got imm=%h alu=%0d rw=%b, want 12340000 6 1", imm_ext, alu_op, reg_write);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(11'h60, 32'h8C220004, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(11'h61, 32'h00432020, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        drive(11'h62, 32'h00C73020, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        n_total++;
        if (stall !== 1'b1)
            $display("FAIL flush_stall_pre: got %b, want 1", stall);
        else n_pass++;
        step();
        n_total++;
        if (dut_vec !== idex_t'('0) || stall !== 1'b0)
            $display("FAIL flush_bubble: got %h stall=%b, want 0 and 0", dut_vec, stall);
        else n_pass++;
        drive(11'h63, 32'hFC432020, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if (pc_out !== 11'd0 || rd !== 5'd0 || rs_data !== 32'd0 || dut_vec !== m_idex)
            $display("FAIL flush_nop: got pc=%h rd=%0d vec=%h, want nop writing r0", pc_out, rd, dut_vec);
        else n_pass++;
        drive(11'h64, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0);
        step();
        n_total++;
        if ({reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, alu_op} !== 10'd0 ||
            rd !== 5'd4 || pc_out !== 11'h63)
            $display("FAIL unknown_op: got outs=%h, want controls 0 rd 4 pc 063", dut_vec);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] ops [11];
        logic [5:0] op;
        logic [31:0] ins;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h3F, 6'h02};
        do_reset();
        for (int i = 0; i < 300; i++) begin
            op  = ops[$urandom_range(0, 10)];
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
            drive(11'($urandom), ins, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
            #1;
            n_total++;
            if (stall !== ref_stall())
                $display("FAIL rand_stall[%0d]: got %b, want %b", i, stall, ref_stall());
            else n_pass++;
            step();
            n_total++;
            if (dut_vec !== m_idex)
                $display("FAIL rand_idex[%0d]: got %h, want %h", i, dut_vec, m_idex);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_bypass();
        test_load_use();
        test_immediates();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
